// File: rtl/debounce_oneshot_pkg.sv
// Shared state encoding and default constants for the switch debouncer.
// The release pulse is built only when DEBOUNCE_RELEASE_PULSE_EN is defined.
package debounce_oneshot_pkg;

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  localparam int DEFAULT_DEBOUNCE_TICKS = 500000;
  localparam int DEFAULT_CNT_WIDTH      = 20;

  function automatic logic is_wait(input state_t s);
    return (s == S_WAIT_HI) || (s == S_WAIT_LO);
  endfunction

endpackage

// File: rtl/debounce_oneshot_stability_counter.sv
// Saturating stability counter: counts cycles a candidate level has held.
// done flags the final qualifying cycle; the count never wraps.
module stability_counter
  import debounce_oneshot_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_TICKS - 1);

  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign done = (r_cnt == LAST);

endmodule

// File: rtl/debounce_oneshot.sv
// Debouncer FSM with registered level, press pulse and optional release pulse.
// Define DEBOUNCE_RELEASE_PULSE_EN to enable release_pulse; otherwise it is tied low.
module debounce_oneshot
  import debounce_oneshot_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_sync,
  output logic db_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic busy
);

  state_t r_state;
  state_t w_next;
  logic   w_done;
  logic   w_clr;
  logic   w_en;
  logic   r_db_level;
  logic   r_press;
  logic   r_busy;

  stability_counter #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (w_clr),
    .en     (w_en),
    .done   (w_done)
  );

  // Counter runs only while a wait state is held; any transition or stable state clears it.
  always_comb begin
    w_next = S_LOW;
    w_clr  = 1'b1;
    w_en   = 1'b0;
    case (r_state)
      S_LOW:     w_next = sw_sync ? S_WAIT_HI : S_LOW;
      S_WAIT_HI: begin
        if (!sw_sync) begin
          w_next = S_LOW;
        end else if (w_done) begin
          w_next = S_HIGH;
        end else begin
          w_next = S_WAIT_HI;
          w_clr  = 1'b0;
          w_en   = 1'b1;
        end
      end
      S_HIGH:    w_next = sw_sync ? S_HIGH : S_WAIT_LO;
      S_WAIT_LO: begin
        if (sw_sync) begin
          w_next = S_HIGH;
        end else if (w_done) begin
          w_next = S_LOW;
        end else begin
          w_next = S_WAIT_LO;
          w_clr  = 1'b0;
          w_en   = 1'b1;
        end
      end
      default:   w_next = S_LOW;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_LOW;
      r_db_level <= 1'b0;
      r_press    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_db_level <= (w_next == S_HIGH) || (w_next == S_WAIT_LO);
      r_press    <= (r_state == S_WAIT_HI) && (w_next == S_HIGH);
      r_busy     <= is_wait(w_next);
    end
  end

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic r_release;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_release <= 1'b0;
    end else begin
      r_release <= (r_state == S_WAIT_LO) && (w_next == S_LOW);
    end
  end

  assign release_pulse = r_release;
`else
  assign release_pulse = 1'b0;
`endif

  assign db_level    = r_db_level;
  assign press_pulse = r_press;
  assign busy        = r_busy;

endmodule

// File: tb/tb_debounce_oneshot.sv
// Self-checking bench for debounce_oneshot (DEBOUNCE_TICKS=4, CNT_WIDTH=3).
// Reference model: a new level must be sampled on TICKS+1 consecutive edges to be accepted.
module tb_debounce_oneshot;

  localparam int TICKS = 4;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic sw_sync = 1'b0;
  logic db_level, press_pulse, release_pulse, busy;

  int n_tests = 0;
  int n_fail  = 0;

  bit m_db, m_press, m_rel, m_busy;
  int m_run;

  debounce_oneshot #(
    .DEBOUNCE_TICKS(TICKS),
    .CNT_WIDTH     (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sw_sync      (sw_sync),
    .db_level     (db_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_db = 0; m_press = 0; m_rel = 0; m_busy = 0; m_run = 0;
  endtask

  // Run-length model: count consecutive samples that disagree with the accepted level.
  task automatic model_update(input logic s);
    m_press = 0;
    m_rel   = 0;
    if (s != m_db) begin
      m_run++;
      if (m_run == TICKS + 1) begin
        m_db  = s;
        m_run = 0;
        if (s) m_press = 1;
        else   m_rel   = REL_EN;
      end
    end else begin
      m_run = 0;
    end
    m_busy = (m_run != 0);
  endtask

  // Drive one sample, clock it, update the model, land 1 time unit after the edge.
  task automatic step(input logic s);
    sw_sync = s;
    @(posedge clk);
    if (!reset_n) model_reset();
    else          model_update(s);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      sw_sync = i[0];
      @(posedge clk);
      #1;
      n_tests++;
      if ({db_level, press_pulse, release_pulse, busy} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %b want 0000", i, {db_level, press_pulse, release_pulse, busy});
      end
    end
    sw_sync = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0);
      n_tests++;
      if ({db_level, press_pulse, release_pulse, busy} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got %b want 0000", i, {db_level, press_pulse, release_pulse, busy});
      end
    end
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_tbl [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000};
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      n_tests++;
      if ({db_level, press_pulse, release_pulse, busy} !== exp_tbl[i] ||
          {db_level, press_pulse, release_pulse, busy} !== {m_db, m_press, m_rel, m_busy}) begin
        n_fail++;
        $display("FAIL clean_press edge k+%0d: got %b want %b", i, {db_level, press_pulse, release_pulse, busy}, exp_tbl[i]);
      end
    end
  endtask

  task automatic test_glitch();
    logic       stim    [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] exp_tbl [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      step(stim[i]);
      n_tests++;
      if ({db_level, press_pulse, release_pulse, busy} !== exp_tbl[i] ||
          {db_level, press_pulse, release_pulse, busy} !== {m_db, m_press, m_rel, m_busy}) begin
        n_fail++;
        $display("FAIL glitch cyc %0d: got %b want %b", i, {db_level, press_pulse, release_pulse, busy}, exp_tbl[i]);
      end
    end
  endtask

  task automatic test_bouncy_release();
    logic       stim    [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] exp_tbl [9];
    exp_tbl = '{4'b1000, 4'b1001, 4'b1000, 4'b1001, 4'b1001, 4'b1001, 4'b1001,
                {2'b00, REL_EN, 1'b0}, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      step(stim[i]);
      n_tests++;
      if ({db_level, press_pulse, release_pulse, busy} !== exp_tbl[i] ||
          {db_level, press_pulse, release_pulse, busy} !== {m_db, m_press, m_rel, m_busy}) begin
        n_fail++;
        $display("FAIL bouncy_release cyc %0d: got %b want %b", i, {db_level, press_pulse, release_pulse, busy}, exp_tbl[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] exp_tbl [5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b1100};
    step(1'b1);
    step(1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({db_level, press_pulse, release_pulse, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %b want 0000", {db_level, press_pulse, release_pulse, busy});
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      n_tests++;
      if ({db_level, press_pulse, release_pulse, busy} !== exp_tbl[i] ||
          {db_level, press_pulse, release_pulse, busy} !== {m_db, m_press, m_rel, m_busy}) begin
        n_fail++;
        $display("FAIL mid_reset_requal edge %0d: got %b want %b", i, {db_level, press_pulse, release_pulse, busy}, exp_tbl[i]);
      end
    end
  endtask

  task automatic test_random();
    logic lvl;
    int   hold;
    int   cyc = 0;
    int   n_press = 0;
    while (cyc < 600) begin
      lvl  = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 8);
      for (int j = 0; j < hold; j++) begin
        step(lvl);
        cyc++;
        if (m_press) n_press++;
        n_tests++;
        if ({db_level, press_pulse, release_pulse, busy} !== {m_db, m_press, m_rel, m_busy}) begin
          n_fail++;
          $display("FAIL random cyc %0d: got %b want %b", cyc, {db_level, press_pulse, release_pulse, busy}, {m_db, m_press, m_rel, m_busy});
        end
      end
    end
    $display("[TB] random: %0d cycles, %0d qualified presses", cyc, n_press);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch_from_high_setup();
    test_glitch();
    test_bouncy_release_setup();
    test_bouncy_release();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Return to a settled low level before the glitch scenario.
  task automatic test_glitch_from_high_setup();
    for (int i = 0; i < TICKS + 2; i++) step(1'b0);
  endtask

  // Settle at a debounced high level before the bouncy release.
  task automatic test_bouncy_release_setup();
    for (int i = 0; i < TICKS + 2; i++) step(1'b1);
    n_tests++;
    if ({db_level, press_pulse, release_pulse, busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL high_setup: got %b want 1000", {db_level, press_pulse, release_pulse, busy});
    end
  endtask

endmodule
